sdram_page_writer: RTL and testbench
====================================

Name: sdram_page_writer

Overview:
- Write-side feeder for the full-page SDRAM controller. It collects the 16-bit pixel stream from the thermal camera/scaler into two ping-pong 512-word page buffers.
- Each full buffer is written to SDRAM as one full-page burst, using the controller's rw/rw_en/f_addr request and its f2s_data/f2s_data_valid burst handshake.
- Page addresses are generated sequentially within a frame region. A new frame restarts the address sequence at BASE_PAGE.

Parameters:
- PAGE_WORDS, 512, words per SDRAM full-page burst; fixed by the controller.
- FRAME_PAGES, 150, pages per frame (320x240x16b = 76800 words).
- BASE_PAGE, 0, first 15-bit page address {row[12:0],bank[1:0]} of the frame region.

Ports:
- clk  in  1  system clock (143 MHz, same domain as the controller)
- rst_n  in  1  asynchronous, active-low reset
- pix_data  in  16  pixel word
- pix_valid  in  1  pixel strobe, one word per asserted cycle
- pix_sof  in  1  start of frame; qualifies the pix_data word in the same cycle
- rw  out  1  to controller; constant 0 (write)
- rw_en  out  1  to controller; burst request
- f_addr  out  15  to controller; page address
- f2s_data  out  16  to controller; burst write word
- f2s_data_valid  in  1  from controller; current f2s_data is consumed this cycle
- ready  in  1  from controller; idle and able to accept a request
- overflow  out  1  sticky; a pixel was dropped because both buffers were full
- frame_done  out  1  one-cycle pulse after the last page of a frame is burst

Behaviour:
- Reset (async): both buffers empty, fill pointer 0, page counter 0, FSM IDLE.
- Reset values: rw_en=0, rw=0, f_addr=BASE_PAGE, f2s_data=0, overflow=0, frame_done=0.
- Fill side:
  - Each pix_valid writes pix_data to buffer[fill_sel][wr_ptr], then wr_ptr++.
  - At wr_ptr=511: mark buffer full, toggle fill_sel, wrap wr_ptr to 0.
  - pix_sof with pix_valid: discard the partial fill buffer, set wr_ptr=0, write this word at index 0, and request page counter reset.
  - If the page counter reset is requested while a burst is in flight, it is applied after that burst completes.
  - If the target fill buffer is full (being drained or queued), the word is dropped and overflow is set; it clears only on reset.
- Drain FSM states: IDLE, REQ, WAIT, BURST, DONE.
  - IDLE: any full buffer present -> drain_sel = oldest full buffer, go to REQ.
  - REQ: rw_en=1 and f_addr=BASE_PAGE+page_cnt, held until a cycle with ready=1. That cycle counts as accepted; go to WAIT. rw_en must be 0 the cycle after acceptance.
  - WAIT: f2s_data already shows buffer[drain_sel][0]. First f2s_data_valid -> BURST with rd_ptr advancing.
  - BURST: each f2s_data_valid advances rd_ptr. f2s_data must show the word at the new rd_ptr in the next cycle (show-ahead).
    - RAM read address = f2s_data_valid ? rd_ptr+1 : rd_ptr, with a registered output.
    - After exactly 512 valid cycles, go to DONE.
    - A gap in f2s_data_valid holds rd_ptr and f2s_data.
  - DONE (one cycle): mark drain buffer empty. page_cnt = (page_cnt==FRAME_PAGES-1 || pending sof) ? 0 : page_cnt+1. Pulse frame_done if page_cnt was FRAME_PAGES-1. Go to IDLE.
- Simultaneous events:
  - A buffer becoming full in the same cycle as DONE is queued normally.
  - Fill into the buffer being emptied in DONE is not allowed until the following cycle.
- Latency: the burst request is raised 2 cycles after the 512th pixel write (one to IDLE, one to REQ).
- Widths: page_cnt is 8 bits. The f_addr sum wraps modulo 2^15.

Decomposition:
- Package sdram_pkg:
  - PAGE_WORDS=512 and the PAGE_ADDR_W=15 / DATA_W=16 constants.
  - Drain FSM state encoding.
  - Controller-facing constants shared with the controller.
- Sub-module sdram_pingpong_ram: 2x512x16 simple dual-port BRAM. Write port {sel,addr,data,we}; read port {sel,addr} with a 1-cycle registered output.

Test Plan:
- 512 pixels, then controller model with ready=1 and 512 consecutive valid cycles -> one rw_en pulse with f_addr=0; SDRAM model captures words 0..511 in order; buffer freed.
- ready=0 for 40 cycles (refresh) during REQ -> rw_en held high with f_addr stable; accepted on the first ready=1 cycle; deasserted the next cycle.
- Valid gaps inserted mid-burst (deassert at words 100 and 300 for 3 cycles) -> no skipped or duplicated words.
- Full frame, FRAME_PAGES=150 -> page addresses 0..149; frame_done pulses once after page 149; next page address is 0.
- Stall drain for 1100 continuous pixels -> both buffers fill; overflow=1 from pixel 1025; buffered data remains intact.
- pix_sof at pixel 200 of page 3 -> partial data discarded; next burst carries new-frame words 0..511 at f_addr=BASE_PAGE. Async reset mid-BURST -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/sdram_pkg.sv
// Shared constants and drain FSM encoding for the SDRAM page writer and
// the full-page SDRAM controller it feeds.
package sdram_pkg;

    localparam int unsigned PAGE_WORDS  = 512;
    localparam int unsigned PTR_W       = 9;
    localparam int unsigned PAGE_ADDR_W = 15;
    localparam int unsigned DATA_W      = 16;
    localparam int unsigned PAGE_CNT_W  = 8;

    // Controller rw encoding
    localparam logic CMD_WRITE = 1'b0;
    localparam logic CMD_READ  = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_BURST,
        ST_DONE
    } drain_state_e;

endpackage

// File: rtl/sdram_pingpong_ram.sv
// Two 512x16 page buffers in one simple dual-port RAM; the read port has a
// registered output that feeds f2s_data directly.
module sdram_pingpong_ram
    import sdram_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [PTR_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_sel,
    input  logic [PTR_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [2*PAGE_WORDS];
    logic [DATA_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[{wr_sel, wr_addr}] <= wr_data;
        end
    end

    // Output register is reset so the burst data bus idles at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem_q[{rd_sel, rd_addr}];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/sdram_page_writer.sv
// Collects the pixel stream into ping-pong page buffers and writes each full
// buffer to SDRAM as one full-page burst at sequential page addresses.
module sdram_page_writer
    import sdram_pkg::*;
#(
    parameter int unsigned FRAME_PAGES = 150,
    parameter int unsigned BASE_PAGE   = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    input  logic        pix_sof,
    output logic        rw,
    output logic        rw_en,
    output logic [14:0] f_addr,
    output logic [15:0] f2s_data,
    input  logic        f2s_data_valid,
    input  logic        ready,
    output logic        overflow,
    output logic        frame_done
);

    drain_state_e           state_q, state_d;
    logic [1:0]             full_q, full_d, full_set, full_clr;
    logic                   fill_sel_q, fill_sel_d;
    logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
    logic                   drain_sel_q, drain_sel_d;
    logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
    logic [PAGE_CNT_W-1:0]  page_cnt_q, page_cnt_d;
    logic                   sof_pend_q, sof_pend_d;
    logic                   overflow_q, overflow_d;
    logic                   frame_done_q, frame_done_d;
    logic                   rw_en_q, rw_en_d;
    logic [PAGE_ADDR_W-1:0] f_addr_q, f_addr_d;

    logic                   ram_we;
    logic [PTR_W-1:0]       ram_waddr;
    logic [PTR_W-1:0]       ram_raddr;
    logic                   sof_now;
    logic                   last_page;
    logic                   draining;

    assign sof_now   = pix_valid & pix_sof;
    assign last_page = (page_cnt_q == PAGE_CNT_W'(FRAME_PAGES - 1));
    assign draining  = (state_q == ST_WAIT) || (state_q == ST_BURST);
    assign full_d    = (full_q | full_set) & ~full_clr;

    // Show-ahead read: look one word ahead whenever the controller consumes
    assign ram_raddr = (draining && f2s_data_valid) ? rd_ptr_q + 1'b1 : rd_ptr_q;

    // Fill side: sof restarts the current buffer at index 0
    always_comb begin
        fill_sel_d = fill_sel_q;
        wr_ptr_d   = wr_ptr_q;
        overflow_d = overflow_q;
        full_set   = '0;
        ram_we     = 1'b0;
        ram_waddr  = pix_sof ? '0 : wr_ptr_q;
        if (pix_valid) begin
            if (pix_sof) begin
                wr_ptr_d = '0;
            end
            if (full_q[fill_sel_q]) begin
                overflow_d = 1'b1;
            end else begin
                ram_we = 1'b1;
                if (ram_waddr == PTR_W'(PAGE_WORDS - 1)) begin
                    full_set[fill_sel_q] = 1'b1;
                    fill_sel_d           = ~fill_sel_q;
                    wr_ptr_d             = '0;
                end else begin
                    wr_ptr_d = ram_waddr + 1'b1;
                end
            end
        end
    end

    // Drain FSM and page address sequencing
    always_comb begin
        state_d      = state_q;
        drain_sel_d  = drain_sel_q;
        rd_ptr_d     = rd_ptr_q;
        page_cnt_d   = page_cnt_q;
        sof_pend_d   = sof_pend_q;
        rw_en_d      = rw_en_q;
        f_addr_d     = f_addr_q;
        frame_done_d = 1'b0;
        full_clr     = '0;

        // With nothing queued or in flight the new frame can restart at once
        if (sof_now) begin
            if ((state_q == ST_IDLE) && (full_q == 2'b00)) begin
                page_cnt_d = '0;
            end else begin
                sof_pend_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (|full_q) begin
                    // Both full means fill_sel has wrapped back onto the oldest
                    drain_sel_d = (&full_q) ? fill_sel_q : full_q[1];
                    rd_ptr_d    = '0;
                    rw_en_d     = 1'b1;
                    f_addr_d    = PAGE_ADDR_W'(BASE_PAGE) + PAGE_ADDR_W'(page_cnt_q);
                    state_d     = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ready) begin
                    rw_en_d = 1'b0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (f2s_data_valid) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    state_d  = ST_BURST;
                end
            end
            ST_BURST: begin
                if (f2s_data_valid) begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                    if (rd_ptr_q == PTR_W'(PAGE_WORDS - 1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                full_clr[drain_sel_q] = 1'b1;
                frame_done_d          = last_page;
                page_cnt_d            = (last_page || sof_pend_q || sof_now) ? '0 : page_cnt_q + 1'b1;
                sof_pend_d            = 1'b0;
                state_d               = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            full_q       <= '0;
            fill_sel_q   <= 1'b0;
            wr_ptr_q     <= '0;
            drain_sel_q  <= 1'b0;
            rd_ptr_q     <= '0;
            page_cnt_q   <= '0;
            sof_pend_q   <= 1'b0;
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
            rw_en_q      <= 1'b0;
            f_addr_q     <= PAGE_ADDR_W'(BASE_PAGE);
        end else begin
            state_q      <= state_d;
            full_q       <= full_d;
            fill_sel_q   <= fill_sel_d;
            wr_ptr_q     <= wr_ptr_d;
            drain_sel_q  <= drain_sel_d;
            rd_ptr_q     <= rd_ptr_d;
            page_cnt_q   <= page_cnt_d;
            sof_pend_q   <= sof_pend_d;
            overflow_q   <= overflow_d;
            frame_done_q <= frame_done_d;
            rw_en_q      <= rw_en_d;
            f_addr_q     <= f_addr_d;
        end
    end

    sdram_pingpong_ram u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (ram_we),
        .wr_sel  (fill_sel_q),
        .wr_addr (ram_waddr),
        .wr_data (pix_data),
        .rd_sel  (drain_sel_q),
        .rd_addr (ram_raddr),
        .rd_data (f2s_data)
    );

    assign rw         = CMD_WRITE;
    assign rw_en      = rw_en_q;
    assign f_addr     = f_addr_q;
    assign overflow   = overflow_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sdram_page_writer.sv
// Directed bench for sdram_page_writer with a small full-page controller
// model that logs accepted page addresses and consumed burst words.
module tb_sdram_page_writer;

    localparam int unsigned FP = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] pix_data;
    logic        pix_valid;
    logic        pix_sof;
    logic        rw;
    logic        rw_en;
    logic [14:0] f_addr;
    logic [15:0] f2s_data;
    logic        f2s_data_valid;
    logic        ready;
    logic        overflow;
    logic        frame_done;

    int          n_cmp = 0;
    int          n_mis = 0;
    logic        stall_ready;
    logic        gap_mode;
    int          fd_cnt;
    logic [15:0] data_log [$];
    logic [14:0] addr_log [$];

    sdram_page_writer #(
        .FRAME_PAGES (FP),
        .BASE_PAGE   (0)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pix_data       (pix_data),
        .pix_valid      (pix_valid),
        .pix_sof        (pix_sof),
        .rw             (rw),
        .rw_en          (rw_en),
        .f_addr         (f_addr),
        .f2s_data       (f2s_data),
        .f2s_data_valid (f2s_data_valid),
        .ready          (ready),
        .overflow       (overflow),
        .frame_done     (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Controller model: accepts requests when not stalled, then streams 512
    // valid cycles, optionally with 3-cycle gaps before words 100 and 300.
    initial begin : ctrl_model
        int          cm_st;
        int          cm_word;
        int          cm_gap;
        logic        req_seen;
        logic [14:0] req_addr;
        cm_st = 0; cm_word = 0; cm_gap = 0; req_seen = 1'b0; req_addr = '0;
        ready = 1'b1;
        f2s_data_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                cm_st = 0;
                req_seen = 1'b0;
                ready = 1'b1;
                f2s_data_valid = 1'b0;
                data_log.delete();
                addr_log.delete();
            end else begin
                case (cm_st)
                    0: begin
                        f2s_data_valid = 1'b0;
                        if (req_seen) chk("req_held", 32'(rw_en), 1);
                        ready = !stall_ready;
                        if (rw_en) begin
                            if (req_seen) chk("req_addr_stable", 32'(f_addr), 32'(req_addr));
                            req_addr = f_addr;
                            if (ready) begin
                                addr_log.push_back(f_addr);
                                req_seen = 1'b0;
                                cm_st = 1;
                            end else begin
                                req_seen = 1'b1;
                            end
                        end else begin
                            req_seen = 1'b0;
                        end
                    end
                    1: begin
                        chk("req_drop", 32'(rw_en), 0);
                        ready = 1'b0;
                        cm_word = 0;
                        cm_gap = 0;
                        cm_st = 2;
                    end
                    2: begin
                        if (gap_mode && (cm_word == 100 || cm_word == 300) && cm_gap < 3) begin
                            f2s_data_valid = 1'b0;
                            cm_gap++;
                        end else begin
                            f2s_data_valid = 1'b1;
                            data_log.push_back(f2s_data);
                            cm_word++;
                            cm_gap = 0;
                            if (cm_word == 512) cm_st = 3;
                        end
                    end
                    default: begin
                        f2s_data_valid = 1'b0;
                        cm_st = 0;
                    end
                endcase
            end
        end
    end

    initial begin : fd_monitor
        fd_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) fd_cnt = 0;
            else if (frame_done) fd_cnt++;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_pixels(input logic [15:0] base, input int n, input logic sof);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pix_valid = 1'b1;
            pix_data  = base + 16'(i);
            pix_sof   = sof && (i == 0);
        end
        @(negedge clk);
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    task automatic check_burst(input string tag, input logic [14:0] exp_addr, input logic [15:0] base);
        int t;
        t = 0;
        while (data_log.size() < 512 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_complete"}, 32'(data_log.size() >= 512 && addr_log.size() > 0), 1);
        if (data_log.size() >= 512 && addr_log.size() > 0) begin
            chk({tag, "_addr"}, 32'(addr_log.pop_front()), 32'(exp_addr));
            for (int i = 0; i < 512; i++) begin
                chk({tag, "_word"}, 32'(data_log.pop_front()), 32'(base + 16'(i)));
            end
        end
    endtask

    initial begin : main
        pix_valid = 1'b0; pix_sof = 1'b0; pix_data = '0;
        stall_ready = 1'b0; gap_mode = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rw_en", 32'(rw_en), 0);
        chk("rst_rw", 32'(rw), 0);
        chk("rst_f_addr", 32'(f_addr), 0);
        chk("rst_f2s_data", 32'(f2s_data), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_frame_done", 32'(frame_done), 0);
        do_reset();

        // Single page, request latency and in-order burst
        send_pixels(16'h1000, 512, 1'b0);
        chk("lat_idle", 32'(rw_en), 0);
        @(negedge clk);
        chk("lat_req", 32'(rw_en), 1);
        chk("lat_addr", 32'(f_addr), 0);
        check_burst("p0", 15'd0, 16'h1000);
        chk("p0_no_frame_done", 32'(fd_cnt), 0);

        // Refresh stall while requesting
        stall_ready = 1'b1;
        send_pixels(16'h2000, 512, 1'b0);
        repeat (42) @(negedge clk);
        chk("stall_req", 32'(rw_en), 1);
        chk("stall_addr", 32'(f_addr), 1);
        stall_ready = 1'b0;
        check_burst("stall", 15'd1, 16'h2000);

        // Valid gaps mid-burst
        gap_mode = 1'b1;
        send_pixels(16'h3000, 512, 1'b0);
        check_burst("gap", 15'd2, 16'h3000);
        gap_mode = 1'b0;

        // Whole frame, then address wraps to the base page
        do_reset();
        for (int p = 0; p < FP; p++) begin
            send_pixels(16'(p * 512), 512, 1'b0);
            repeat (16) @(negedge clk);
        end
        for (int p = 0; p < FP; p++) begin
            check_burst("frame", 15'(p), 16'(p * 512));
        end
        repeat (4) @(negedge clk);
        chk("frame_done_once", 32'(fd_cnt), 1);
        send_pixels(16'h7000, 512, 1'b0);
        check_burst("wrap", 15'd0, 16'h7000);
        repeat (4) @(negedge clk);
        chk("frame_done_wrap", 32'(fd_cnt), 1);

        // Both buffers fill while the controller stalls
        do_reset();
        stall_ready = 1'b1;
        send_pixels(16'h4000, 1024, 1'b0);
        chk("ovf_before", 32'(overflow), 0);
        send_pixels(16'h4400, 1, 1'b0);
        chk("ovf_at_1025", 32'(overflow), 1);
        send_pixels(16'h4401, 75, 1'b0);
        stall_ready = 1'b0;
        check_burst("ovf_p0", 15'd0, 16'h4000);
        check_burst("ovf_p1", 15'd1, 16'h4200);
        chk("ovf_sticky", 32'(overflow), 1);

        // Start of frame during an in-flight burst
        do_reset();
        chk("ovf_cleared", 32'(overflow), 0);
        for (int p = 0; p < 3; p++) begin
            send_pixels(16'h5000 + 16'(p * 512), 512, 1'b0);
            repeat (16) @(negedge clk);
        end
        send_pixels(16'h5a00, 200, 1'b0);
        send_pixels(16'h6000, 512, 1'b1);
        for (int p = 0; p < 3; p++) begin
            check_burst("sof_old", 15'(p), 16'h5000 + 16'(p * 512));
        end
        check_burst("sof_new", 15'd0, 16'h6000);

        // Async reset mid-burst
        send_pixels(16'h7100, 512, 1'b0);
        begin
            int t;
            t = 0;
            while (data_log.size() < 100 && t < 2000) begin
                @(negedge clk);
                t++;
            end
        end
        chk("arst_burst_started", 32'(data_log.size() >= 100 && addr_log.size() > 0), 1);
        if (addr_log.size() > 0) chk("arst_addr", 32'(addr_log[0]), 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_rw_en", 32'(rw_en), 0);
        chk("arst_rw", 32'(rw), 0);
        chk("arst_f_addr", 32'(f_addr), 0);
        chk("arst_f2s_data", 32'(f2s_data), 0);
        chk("arst_overflow", 32'(overflow), 0);
        chk("arst_frame_done", 32'(frame_done), 0);
        do_reset();
        send_pixels(16'h0a00, 512, 1'b0);
        check_burst("post_rst", 15'd0, 16'h0a00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
